// File: rtl/cpu_run_monitor_if.sv
// rtl/cpu_run_monitor_if.sv - CPU snoop signals observed by cpu_run_monitor
interface cpu_run_monitor_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              clk_enable;
    logic              active;
    logic [ADDR_W-1:0] instr_address;
    logic [DATA_W-1:0] register_v0;

    modport master (
        output clk_enable,
        output active,
        output instr_address,
        output register_v0
    );

    modport slave (
        input clk_enable,
        input active,
        input instr_address,
        input register_v0
    );
endinterface

// File: rtl/cpu_run_monitor.sv
// rtl/cpu_run_monitor.sv - pass/fail run monitor for CPU directed tests
// Optional misaligned-PC check: define CPU_RUN_MONITOR_ALIGN_CHECK_EN.
module cpu_run_monitor #(
    parameter int                 ADDR_W       = 32,
    parameter int                 DATA_W       = 32,
    parameter int                 CNT_W        = 16,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = ADDR_W'(32'hBFC00000),
    parameter logic [ADDR_W-1:0]  HALT_ADDR    = '0,
    parameter int                 TIMEOUT      = 1000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    cpu_run_monitor_if.slave  cpu,
    input  logic [DATA_W-1:0] expected_v0,
    output logic              done,
    output logic              pass,
    output logic [2:0]        fail_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  fetch_count,
    output logic [CNT_W-1:0]  branch_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    localparam logic [2:0] FC_NONE       = 3'd0;
    localparam logic [2:0] FC_BAD_VECTOR = 3'd1;
    localparam logic [2:0] FC_WRONG_V0   = 3'd2;
    localparam logic [2:0] FC_TIMEOUT    = 3'd3;
    localparam logic [2:0] FC_MISALIGNED = 3'd4;
    localparam logic [2:0] FC_ACTIVE_LOW = 3'd5;

    // Compared zero-extended so a TIMEOUT beyond the counter range simply never fires.
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [2:0]         fail_code_q, fail_code_d;
    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;
    logic [CNT_W-1:0]   branch_count_q, branch_count_d;
    logic [ADDR_W-1:0]  prev_addr_q, prev_addr_d;

    logic [ADDR_W-1:0]  seq_addr;
    logic               timeout_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign seq_addr    = prev_addr_q + ADDR_W'(4);
    assign timeout_hit = (32'(cycle_count_q) == TIMEOUT_LAST);

    always_comb begin
        state_d        = state_q;
        fail_code_d    = fail_code_q;
        cycle_count_d  = cycle_count_q;
        fetch_count_d  = fetch_count_q;
        branch_count_d = branch_count_q;
        prev_addr_d    = prev_addr_q;

        if (clear) begin
            state_d        = S_IDLE;
            fail_code_d    = FC_NONE;
            cycle_count_d  = '0;
            fetch_count_d  = '0;
            branch_count_d = '0;
            prev_addr_d    = '0;
        end else if (cpu.clk_enable) begin
            case (state_q)
                S_IDLE: begin
                    if (cpu.active) begin
                        if (cpu.instr_address == RESET_VECTOR) begin
                            state_d       = S_RUN;
                            fetch_count_d = CNT_W'(1);
                            prev_addr_d   = cpu.instr_address;
                        end else begin
                            state_d     = S_FAIL;
                            fail_code_d = FC_BAD_VECTOR;
                        end
                    end
                end
                S_RUN: begin
                    // Halt is checked first so it beats a same-edge timeout.
                    if (cpu.instr_address == HALT_ADDR) begin
                        if (cpu.register_v0 == expected_v0) begin
                            state_d = S_PASS;
                        end else begin
                            state_d     = S_FAIL;
                            fail_code_d = FC_WRONG_V0;
                        end
                    end
`ifdef CPU_RUN_MONITOR_ALIGN_CHECK_EN
                    else if (cpu.instr_address[1:0] != 2'b00) begin
                        state_d     = S_FAIL;
                        fail_code_d = FC_MISALIGNED;
                    end
`endif
                    else if (!cpu.active) begin
                        state_d     = S_FAIL;
                        fail_code_d = FC_ACTIVE_LOW;
                    end else if (timeout_hit) begin
                        state_d     = S_FAIL;
                        fail_code_d = FC_TIMEOUT;
                    end else begin
                        cycle_count_d = sat_inc(cycle_count_q);
                        if (cpu.instr_address != prev_addr_q) begin
                            fetch_count_d = sat_inc(fetch_count_q);
                            if (cpu.instr_address != seq_addr) begin
                                branch_count_d = sat_inc(branch_count_q);
                            end
                        end
                        prev_addr_d = cpu.instr_address;
                    end
                end
                default: ;
            endcase
        end

        done_d = (state_d == S_PASS) || (state_d == S_FAIL);
        pass_d = (state_d == S_PASS);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            fail_code_q    <= FC_NONE;
            cycle_count_q  <= '0;
            fetch_count_q  <= '0;
            branch_count_q <= '0;
            prev_addr_q    <= '0;
        end else begin
            state_q        <= state_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            fail_code_q    <= fail_code_d;
            cycle_count_q  <= cycle_count_d;
            fetch_count_q  <= fetch_count_d;
            branch_count_q <= branch_count_d;
            prev_addr_q    <= prev_addr_d;
        end
    end

    assign done         = done_q;
    assign pass         = pass_q;
    assign fail_code    = fail_code_q;
    assign cycle_count  = cycle_count_q;
    assign fetch_count  = fetch_count_q;
    assign branch_count = branch_count_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb/tb_cpu_run_monitor.sv - randomized and directed bench for cpu_run_monitor
module tb_cpu_run_monitor;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic [31:0] expected_v0;

    logic        done, pass;
    logic [2:0]  fail_code;
    logic [15:0] cycle_count, fetch_count, branch_count;

    logic        s_done, s_pass;
    logic [2:0]  s_fail_code;
    logic [3:0]  s_cycle_count, s_fetch_count, s_branch_count;

    int checks   = 0;
    int failures = 0;

    bit          tr_act[$];
    logic [31:0] tr_addr[$];
    logic [31:0] tr_v0[$];

    cpu_run_monitor_if cpu_if ();

    cpu_run_monitor #(.TIMEOUT(10)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .cpu(cpu_if),
        .expected_v0(expected_v0), .done(done), .pass(pass), .fail_code(fail_code),
        .cycle_count(cycle_count), .fetch_count(fetch_count), .branch_count(branch_count)
    );

    cpu_run_monitor #(.CNT_W(4), .TIMEOUT(20)) dut_s (
        .clk(clk), .reset_n(reset_n), .clear(clear), .cpu(cpu_if),
        .expected_v0(expected_v0), .done(s_done), .pass(s_pass), .fail_code(s_fail_code),
        .cycle_count(s_cycle_count), .fetch_count(s_fetch_count), .branch_count(s_branch_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_time_limit reached");
        $fatal(1);
    end

    // Trace-driven reference: replays the rules over every enabled sample.
    function automatic void run_model(input int maxc, input int tmo, output bit d, output bit p,
                                      output int code, output int cyc, output int fet, output int br);
        int          st;
        logic [31:0] prev, a;
        st = 0; d = 0; p = 0; code = 0; cyc = 0; fet = 0; br = 0; prev = 0;
        foreach (tr_addr[i]) begin
            a = tr_addr[i];
            if (st == 0) begin
                if (tr_act[i]) begin
                    if (a == RV) begin st = 1; fet = 1; prev = a; end
                    else begin st = 2; code = 1; end
                end
            end else if (st == 1) begin
                if (a == 32'h0) begin st = 2; p = (tr_v0[i] == expected_v0); code = p ? 0 : 2; end
`ifdef CPU_RUN_MONITOR_ALIGN_CHECK_EN
                else if (a[1:0] != 2'b00) begin st = 2; code = 4; end
`endif
                else if (!tr_act[i]) begin st = 2; code = 5; end
                else if (cyc == tmo - 1) begin st = 2; code = 3; end
                else begin
                    cyc = (cyc < maxc) ? cyc + 1 : cyc;
                    if (a != prev) begin
                        fet = (fet < maxc) ? fet + 1 : fet;
                        if (a != prev + 32'd4) br = (br < maxc) ? br + 1 : br;
                    end
                    prev = a;
                end
            end
        end
        d = (st == 2);
    endfunction

    task automatic step(input bit en, input bit act, input logic [31:0] addr, input logic [31:0] v0);
        @(negedge clk);
        clear                = 1'b0;
        cpu_if.clk_enable    = en;
        cpu_if.active        = act;
        cpu_if.instr_address = addr;
        cpu_if.register_v0   = v0;
        if (en) begin
            tr_act.push_back(act);
            tr_addr.push_back(addr);
            tr_v0.push_back(v0);
        end
    endtask

    task automatic settle();
        step(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic restart();
        @(negedge clk);
        clear             = 1'b1;
        cpu_if.clk_enable = 1'b1;
        cpu_if.active     = 1'b0;
        tr_act.delete();
        tr_addr.delete();
        tr_v0.delete();
    endtask

    task automatic play_straight(input logic [31:0] halt_v0);
        step(1, 1, RV, 32'h5);
        step(1, 1, RV, 32'h5);
        step(1, 1, RV + 32'h4, 32'h6);
        step(1, 1, RV + 32'h8, 32'h7);
        step(1, 1, 32'h0, halt_v0);
        settle();
    endtask

    task automatic test_reset();
        checks++;
        if ({done, pass, fail_code, cycle_count, fetch_count, branch_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%b/%0d/%0d/%0d/%0d want=all zero",
                     done, pass, fail_code, cycle_count, fetch_count, branch_count);
        end
    endtask

    task automatic test_straight();
        restart(); expected_v0 = 32'd129;
        play_straight(32'd129);
        checks++; if ({done, pass, fail_code} !== {1'b1, 1'b1, 3'd0}) begin failures++; $display("FAIL straight_verdict got=%b%b code=%0d want=11 code=0", done, pass, fail_code); end
        checks++; if (cycle_count !== 16'd3) begin failures++; $display("FAIL straight_cycle got=%0d want=3", cycle_count); end
        checks++; if (fetch_count !== 16'd3 || branch_count !== 16'd0) begin failures++; $display("FAIL straight_counts got=%0d/%0d want=3/0", fetch_count, branch_count); end
        // Verdict is absorbing: further activity must not move anything.
        step(1, 0, RV + 32'h40, 32'h0);
        step(1, 1, 32'h0, 32'h1);
        settle();
        checks++; if ({done, pass, cycle_count, fetch_count} !== {1'b1, 1'b1, 16'd3, 16'd3}) begin failures++; $display("FAIL absorb_pass got=%b%b %0d/%0d want=11 3/3", done, pass, cycle_count, fetch_count); end
    endtask

    task automatic test_branch();
        logic [31:0] offs[9] = '{32'h00, 32'h00, 32'h04, 32'h08, 32'h0C, 32'h18, 32'h1C, 32'h28, 32'h2C};
        restart(); expected_v0 = 32'd129;
        foreach (offs[i]) step(1, 1, RV + offs[i], 32'h0);
        step(1, 1, 32'h0, 32'd129);
        settle();
        checks++; if (pass !== 1'b1) begin failures++; $display("FAIL branch_pass got=%b want=1", pass); end
        checks++; if (branch_count !== 16'd2 || fetch_count !== 16'd8) begin failures++; $display("FAIL branch_counts got=%0d/%0d want=2/8", branch_count, fetch_count); end
    endtask

    task automatic test_wrong_v0();
        restart(); expected_v0 = 32'd129;
        play_straight(32'd128);
        checks++; if ({done, pass, fail_code} !== {1'b1, 1'b0, 3'd2}) begin failures++; $display("FAIL wrong_v0 got=%b%b code=%0d want=10 code=2", done, pass, fail_code); end
    endtask

    task automatic test_bad_start_and_clear();
        restart(); expected_v0 = 32'd129;
        step(1, 0, RV, 32'h0);
        step(0, 1, RV, 32'h0);
        step(1, 1, RV + 32'h4, 32'h0);
        settle();
        checks++; if ({done, pass, fail_code} !== {1'b1, 1'b0, 3'd1}) begin failures++; $display("FAIL bad_start got=%b%b code=%0d want=10 code=1", done, pass, fail_code); end
        checks++; if ({cycle_count, fetch_count, branch_count} !== '0) begin failures++; $display("FAIL bad_start_counts got=%0d/%0d/%0d want=0/0/0", cycle_count, fetch_count, branch_count); end
        restart();
        settle();
        checks++; if ({done, pass, fail_code} !== 5'b0) begin failures++; $display("FAIL clear_outputs got=%b%b code=%0d want=00 code=0", done, pass, fail_code); end
        play_straight(32'd129);
        checks++; if ({done, pass} !== 2'b11) begin failures++; $display("FAIL clear_rerun got=%b%b want=11", done, pass); end
    endtask

    task automatic test_timeout_stall();
        bit d, p; int code, cyc, fet, br, dummy;
        restart(); expected_v0 = 32'd129;
        step(1, 1, RV, 32'h0);
        for (int k = 1; k <= 9; k++) begin
            step(1, 1, (k % 2 == 1) ? RV + 32'h4 : RV, 32'h0);
            if (k <= 5) step(0, 1, 32'h0, 32'd129);
        end
        settle();
        checks++; if (done !== 1'b0 || cycle_count !== 16'd9) begin failures++; $display("FAIL timeout_early got done=%b cyc=%0d want done=0 cyc=9", done, cycle_count); end
        step(1, 1, RV + 32'h4, 32'h0);
        settle();
        checks++; if ({done, pass, fail_code} !== {1'b1, 1'b0, 3'd3} || cycle_count !== 16'd9) begin failures++; $display("FAIL timeout got=%b%b code=%0d cyc=%0d want=10 code=3 cyc=9", done, pass, fail_code, cycle_count); end
        run_model(65535, 10, d, p, code, cyc, fet, br);
        dummy = 0;
        checks++; if (fetch_count !== 16'(fet) || branch_count !== 16'(br)) begin failures++; $display("FAIL timeout_counts got=%0d/%0d want=%0d/%0d", fetch_count, branch_count, fet, br); end
    endtask

    task automatic test_reset_mid_run();
        restart(); expected_v0 = 32'd129;
        step(1, 1, RV, 32'h0);
        step(1, 1, RV + 32'h4, 32'h0);
        step(1, 1, RV + 32'h10, 32'h0);
        settle();
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({done, pass, fail_code, cycle_count, fetch_count, branch_count} !== '0) begin failures++; $display("FAIL reset_mid_run got=%b%b code=%0d %0d/%0d/%0d want=all zero", done, pass, fail_code, cycle_count, fetch_count, branch_count); end
        @(negedge clk);
        reset_n = 1'b1;
        tr_act.delete(); tr_addr.delete(); tr_v0.delete();
        // Back in IDLE: an active fetch of the halt address is a bad start vector.
        step(1, 1, 32'h0, 32'd129);
        settle();
        checks++; if ({done, fail_code} !== {1'b1, 3'd1}) begin failures++; $display("FAIL reset_to_idle got done=%b code=%0d want done=1 code=1", done, fail_code); end
    endtask

    task automatic test_align();
        restart(); expected_v0 = 32'd129;
        step(1, 1, RV, 32'h0);
        step(1, 1, RV + 32'h2, 32'h0);
`ifdef CPU_RUN_MONITOR_ALIGN_CHECK_EN
        settle();
        checks++; if ({done, pass, fail_code} !== {1'b1, 1'b0, 3'd4}) begin failures++; $display("FAIL align_fail got=%b%b code=%0d want=10 code=4", done, pass, fail_code); end
`else
        step(1, 1, RV + 32'h6, 32'h0);
        step(1, 1, 32'h0, 32'd129);
        settle();
        checks++; if ({done, pass, fetch_count, branch_count} !== {1'b1, 1'b1, 16'd3, 16'd1}) begin failures++; $display("FAIL align_counted got=%b%b %0d/%0d want=11 3/1", done, pass, fetch_count, branch_count); end
`endif
    endtask

    task automatic test_saturate();
        restart(); expected_v0 = 32'd77;
        for (int k = 0; k < 20; k++) step(1, 1, RV + 32'(4 * k), 32'h0);
        step(1, 1, 32'h0, 32'd77);
        settle();
        checks++; if ({s_done, s_pass} !== 2'b11) begin failures++; $display("FAIL sat_verdict got=%b%b want=11", s_done, s_pass); end
        checks++; if (s_cycle_count !== 4'd15 || s_fetch_count !== 4'd15 || s_branch_count !== 4'd0) begin failures++; $display("FAIL sat_counts got=%0d/%0d/%0d want=15/15/0", s_cycle_count, s_fetch_count, s_branch_count); end
        checks++; if (fail_code !== 3'd3) begin failures++; $display("FAIL sat_main_timeout got=%0d want=3", fail_code); end
    endtask

    task automatic test_random();
        bit d, p; int code, cyc, fet, br;
        logic [31:0] cur;
        int r;
        for (int it = 0; it < 40; it++) begin
            restart();
            expected_v0 = $urandom_range(0, 3);
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) step(1, 0, $urandom, $urandom);
            cur = ($urandom_range(0, 7) == 0) ? RV + 32'h4 : RV;
            step(1, 1, cur, $urandom);
            for (int j = 0; j < int'($urandom_range(0, 14)); j++) begin
                r = $urandom_range(0, 19);
                if (r < 2) step(0, 1'($urandom), $urandom, $urandom);
                else if (r < 5) step(1, 1, cur, $urandom);
                else begin
                    if (r < 12) cur = cur + 32'h4;
                    else if (r < 17) cur = RV + ($urandom_range(0, 63) << 2);
                    else cur = cur + 32'h2;
                    step(1, (r != 18), cur, $urandom);
                end
            end
            step(1, 1, 32'h0, ($urandom_range(0, 1) == 1) ? expected_v0 : expected_v0 ^ 32'h1);
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) step(1, 1'($urandom), $urandom_range(0, 1) << 2, $urandom);
            settle();
            run_model(65535, 10, d, p, code, cyc, fet, br);
            checks++; if ({done, pass, fail_code} !== {d, p, 3'(code)}) begin failures++; $display("FAIL rand_verdict it=%0d got=%b%b code=%0d want=%b%b code=%0d", it, done, pass, fail_code, d, p, code); end
            checks++; if ({cycle_count, fetch_count, branch_count} !== {16'(cyc), 16'(fet), 16'(br)}) begin failures++; $display("FAIL rand_counts it=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", it, cycle_count, fetch_count, branch_count, cyc, fet, br); end
            run_model(15, 20, d, p, code, cyc, fet, br);
            checks++; if ({s_done, s_pass, s_fail_code} !== {d, p, 3'(code)}) begin failures++; $display("FAIL rand_sat_verdict it=%0d got=%b%b code=%0d want=%b%b code=%0d", it, s_done, s_pass, s_fail_code, d, p, code); end
            checks++; if ({s_cycle_count, s_fetch_count, s_branch_count} !== {4'(cyc), 4'(fet), 4'(br)}) begin failures++; $display("FAIL rand_sat_counts it=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", it, s_cycle_count, s_fetch_count, s_branch_count, cyc, fet, br); end
        end
    endtask

    initial begin
        reset_n              = 1'b0;
        clear                = 1'b0;
        expected_v0          = 32'd0;
        cpu_if.clk_enable    = 1'b0;
        cpu_if.active        = 1'b0;
        cpu_if.instr_address = 32'h0;
        cpu_if.register_v0   = 32'h0;
        repeat (2) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        test_straight();
        test_branch();
        test_wrong_v0();
        test_bad_start_and_clear();
        test_timeout_stall();
        test_reset_mid_run();
        test_align();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
